// File: rtl/rx_dec_pkg.sv
// Shared definitions for the Rx decimation chain (CIC and half-band stages).
//   ADC_W, CIC_R, CIC_N : default sample width, CIC ratio and stage count
//   clog2()             : ceiling log2, usable in constant expressions
//   round_sat()         : half-up rounding right shift followed by saturation
//                         to a signed out_w-bit range
package rx_dec_pkg;

    localparam int ADC_W = 10;
    localparam int CIC_R = 4;
    localparam int CIC_N = 3;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Works one bit wider than the 32-bit input, so adding the rounding
    // constant to the most positive value can never wrap negative.
    function automatic logic signed [31:0] round_sat(input logic signed [31:0] value,
                                                     input int shift,
                                                     input int out_w);
        logic signed [32:0] wide;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        wide = {value[31], value};
        if (shift > 0) begin
            wide = wide + (33'sd1 <<< (shift - 1));
        end
        wide = wide >>> shift;
        hi   = (33'sd1 <<< (out_w - 1)) - 33'sd1;
        lo   = -(33'sd1 <<< (out_w - 1));
        if (wide > hi) begin
            wide = hi;
        end else if (wide < lo) begin
            wide = lo;
        end
        return wide[31:0];
    endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-stream bundle between the ADC front end, the CIC decimator and the
// half-band stage.
//   in_data/in_valid   : ADC-rate signed samples with qualifier
//   out_data/out_valid : decimated signed samples with one-cycle strobe
//   master : the side that feeds samples and consumes the decimated stream
//   slave  : the decimator itself
interface cic_decimator_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 10
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;

    modport master (output in_data, in_valid, input out_data, out_valid);
    modport slave  (input in_data, in_valid, output out_data, out_valid);
endinterface

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: a W-bit wrapping accumulator that adds `add` on each
// enabled cycle and holds otherwise.
//   clk, rst_n : clock and asynchronous active-low reset (clears acc)
//   en         : accumulate this cycle
//   add        : value to accumulate (previous stage's registered output)
//   acc        : registered accumulator value
module cic_integrator_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] add,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        // NOTE: assign the hold value first so every path drives acc_d and no latch is inferred.
        acc_d = acc_q;
        if (en) begin
            // Modulo 2^W on purpose: the comb differences undo the wrap.
            acc_d = acc_q + add;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            // NOTE: non-blocking so all stages sample each other's old values on the same edge.
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator by R feeding the half-band stage. The integrators run
// at the input rate on in_valid; a phase counter marks every R-th accepted
// sample, which raises dec_en for one cycle. During dec_en the comb chain is
// evaluated combinationally from the last integrator and the result is
// rounded/saturated back to OUT_W bits, removing the R^N gain.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of the sample stream (in_* in, out_* out)
module cic_decimator
    import rx_dec_pkg::*;
#(
    parameter int R     = CIC_R,
    parameter int N     = CIC_N,
    parameter int IN_W  = ADC_W,
    parameter int OUT_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    cic_decimator_if.slave  bus
);

    localparam int ACC_W = IN_W + N * clog2(R);
    localparam int SHIFT = ACC_W - OUT_W;
    localparam int PH_W  = clog2(R);

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] integ [N];

    logic [PH_W-1:0]  phase_q,     phase_d;
    logic             dec_en_q,    dec_en_d;
    logic [ACC_W-1:0] dly_q [N];
    logic [ACC_W-1:0] dly_d [N];
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] comb_out;

    assign in_ext = {{(ACC_W - IN_W){bus.in_data[IN_W-1]}}, bus.in_data};

    // Pipelined integrator chain: each stage adds the previous stage's
    // registered value, giving N-1 extra samples of fixed group delay.
    for (genvar k = 0; k < N; k++) begin : g_integ
        logic [ACC_W-1:0] add_in;
        if (k == 0) begin : g_first
            assign add_in = in_ext;
        end else begin : g_next
            assign add_in = integ[k-1];
        end
        cic_integrator_stage #(.W(ACC_W)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.in_valid),
            .add   (add_in),
            .acc   (integ[k])
        );
    end

    always_comb begin
        logic [ACC_W-1:0] stage_val;

        phase_d = phase_q;
        if (bus.in_valid) begin
            phase_d = (phase_q == PH_W'(R - 1)) ? '0 : phase_q + PH_W'(1);
        end
        dec_en_d = bus.in_valid && (phase_q == PH_W'(R - 1));

        // Comb chain with differential delay 1. integ[N-1] is the registered
        // value, so an integrator update in the dec_en cycle does not leak in.
        dly_d     = dly_q;
        stage_val = integ[N-1];
        for (int k = 0; k < N; k++) begin
            if (dec_en_q) begin
                dly_d[k] = stage_val;
            end
            stage_val = stage_val - dly_q[k];
        end
        comb_out = stage_val;

        out_valid_d = dec_en_q;
        out_data_d  = out_data_q;
        if (dec_en_q) begin
            out_data_d = OUT_W'(round_sat(32'(signed'(comb_out)), SHIFT, OUT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            dec_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            // NOTE: the comb delays are a handful of flops, not a RAM, so reset every element.
            for (int k = 0; k < N; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            dec_en_q    <= dec_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < N; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Multi-stage CIC decimator at the head of the Rx decimation chain. It accepts 10-bit signed ADC-rate samples and decimates them by `R`. It delivers 10-bit signed samples with a valid strobe directly into the half-band decimator input (`in_HB`). CIC gain is removed by rounding and saturation, so the half-band stage sees the same full-scale range as the ADC.

## Interface
- `R`, 4: decimation ratio; power of two, 2..16.
- `N`, 3: number of integrator/comb stages.
- `IN_W`, 10: input sample width.
- `OUT_W`, 10: output sample width (matches half-band input).
- `ACC_W`, `IN_W + N*log2(R)` = 16: internal register width (derived, not overridable).
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  IN_W: signed two's-complement input sample.
- `in_valid`  in  1: input sample qualifier; one sample per high cycle, gaps allowed.
- `out_data`  out  OUT_W: signed decimated sample to the half-band stage.
- `out_valid`  out  1: single-cycle strobe marking a new `out_data`.

## Operation
- Reset (async, `rst_n`=0): all integrator, comb-delay and output registers go to 0. Phase counter goes to 0. `out_data`=0, `out_valid`=0. This applies even mid-frame. The first post-reset output is produced after `R` accepted samples.
- Integrators: registered, pipelined chain. Updated only when `in_valid`=1.
  - `I1 <= I1 + sext(in_data)`.
  - `Ik <= Ik + I(k-1)` using the old `I(k-1)`.
  - Registers hold when `in_valid`=0.
- Integrator arithmetic: modulo 2^ACC_W. Wrap-around is intentional and must not be saturated; comb differences recover the correct value.
- Phase counter: 0..R-1, advances on each `in_valid`. Wraps R-1 → 0.
- Decimation: an accepted sample with counter = R-1 is a decimation sample. One cycle later an internal strobe `dec_en` is high for one cycle.
- Combs: evaluated on `dec_en` with differential delay 1.
  - `c0 = I_N`.
  - `ck = c(k-1) - dk`, then `dk <= c(k-1)`.
  - All in ACC_W modulo arithmetic.
  - The comb chain is combinational within that one cycle; delays are registered.
- Scaling: gain is R^N = 2^(N*log2 R) (= 64 for defaults).
  - `out = (cN + 2^(S-1)) >>> S`, with S = ACC_W - OUT_W = 6.
  - Rounding is half-up.
  - The result is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-512, 511].
  - Computed at ACC_W+1 bits so the rounding add cannot wrap.
- `out_data` holds its value between strobes.
- `in_valid` gaps stall the filter without changing the output sequence.
- Simultaneous `in_valid` and `dec_en`: both proceed independently. Integrators update, and the combs use the `I_N` registered before this cycle's update.

## Timing
- Latency: `out_valid` is high exactly 2 cycles after the clock edge that accepts the decimation sample (1 cycle to `dec_en`, 1 cycle to the output register).
- Throughput: one input per clock. One output per R accepted inputs. `out_valid` is never high in consecutive cycles when R ≥ 2.
- Integrator pipeline: adds N-1 sample delays to the impulse response. This group delay is accepted and fixed.
- No back-pressure. The half-band stage must accept every `out_valid` strobe.

## Structure
- Shared package `rx_dec_pkg` holds:
  - constants `ADC_W=10`, `CIC_R=4`, `CIC_N=3`;
  - a function `clog2`;
  - a function `round_sat(value, shift, out_w)`, reused by the half-band output stage.
- Sub-module `cic_integrator_stage` (width-parameterised accumulator with enable and async reset), instantiated N times. The comb chain and scaler stay in the top module.

## Test plan
- Reset mid-stream: drive 7 samples of 300, assert `rst_n`=0 for 3 cycles, release, then drive a DC input of 200.
  - During reset, `out_data`=0 and `out_valid`=0 immediately (asynchronous).
  - First `out_valid` appears 2 cycles after the 4th accepted post-reset sample.
- DC 100, `in_valid` continuous: `out_valid` every 4 cycles.
  - From the 4th output onward, `out_data`=100.
  - Earlier outputs lie in 0..100 and are non-decreasing.
- Full scale with wrap: DC +511 for 20 outputs gives steady 511. DC -512 for 10000 samples gives steady -512 after settling. Integrators wrap many times with no output glitch.
- Stalls: DC 100 with `in_valid` high one cycle in three. The output sequence equals the continuous case. Latency remains 2 cycles after each 4th accepted sample.
- Nyquist tone: alternating +511/-512 continuous. After settling, every output is within [-2, +2].
- Saturation boundary: the rounding add on a max-positive comb result yields 511, not -512. Check by forcing steady input 511 and confirming no negative output ever appears.
